// File: rtl/mem_responder_if.sv
// Command/response bus between the CPU controller and the memory responder.
// The controller drives the command side; the responder answers with data and status.
interface mem_responder_if;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        mem_ready;
    logic        bus_err;

    modport master (
        output mem_cmd, mem_addr, write_data,
        input  read_data, mem_ready, bus_err
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data,
        output read_data, mem_ready, bus_err
    );
endinterface

// File: rtl/mem_responder.sv
// Wait-state memory responder: 256x16 RAM plus LED register and switch port,
// completing each command with a one-cycle mem_ready pulse.
module mem_responder #(
    parameter int         WAIT_CYCLES = 1,
    parameter logic [8:0] LED_ADDR    = 9'h100,
    parameter logic [8:0] SW_ADDR     = 9'h140
) (
    input  logic           clk,
    input  logic           reset_n,
    mem_responder_if.slave bus,
    output logic [7:0]     led_out,
    input  logic [7:0]     sw_in
);
    localparam logic [1:0] MNONE    = 2'b00;
    localparam logic [1:0] MREAD    = 2'b01;
    localparam logic [1:0] MWRITE   = 2'b11;
    localparam logic [1:0] MILLEGAL = 2'b10;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [1:0]  cmd_q;
    logic [8:0]  addr_q;
    logic [15:0] wdata_q;
    logic [15:0] ram [256];

    logic [1:0]  acc_cmd;
    logic [8:0]  acc_addr;
    logic [15:0] acc_wdata;
    logic        access;
    logic        hit_ram, hit_led, hit_sw, acc_err, ram_we;

    // With zero wait states the access happens on the accepting edge, straight from the bus.
    always_comb begin
        acc_cmd   = cmd_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        access    = 1'b0;
        case (state)
            IDLE: begin
                acc_cmd   = bus.mem_cmd;
                acc_addr  = bus.mem_addr;
                acc_wdata = bus.write_data;
                access    = (bus.mem_cmd != MNONE) && (WAIT_INIT == 4'd0);
            end
            BUSY:    access = (cnt == 4'd1);
            default: access = 1'b0;
        endcase
    end

    assign hit_ram = ~acc_addr[8];
    assign hit_led = (acc_addr == LED_ADDR);
    assign hit_sw  = (acc_addr == SW_ADDR);
    assign acc_err = (acc_cmd == MILLEGAL) || !(hit_ram || hit_led || hit_sw);
    // Gating with reset_n keeps a write from landing while reset is held.
    assign ram_we  = access && reset_n && (acc_cmd == MWRITE) && hit_ram;

    always_ff @(posedge clk) begin
        if (state == IDLE && bus.mem_cmd != MNONE) begin
            cmd_q   <= bus.mem_cmd;
            addr_q  <= bus.mem_addr;
            wdata_q <= bus.write_data;
        end
        if (ram_we)
            ram[acc_addr[7:0]] <= acc_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            bus.mem_ready <= 1'b0;
            bus.bus_err   <= 1'b0;
            bus.read_data <= 16'h0000;
            led_out       <= 8'h00;
        end else begin
            bus.mem_ready <= 1'b0;
            bus.bus_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mem_cmd != MNONE) begin
                        cnt   <= WAIT_INIT;
                        state <= access ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (access)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (access) begin
                bus.mem_ready <= 1'b1;
                bus.bus_err   <= acc_err;
                if (acc_err)
                    bus.read_data <= 16'h0000;
                else if (acc_cmd == MREAD) begin
                    if (hit_ram)
                        bus.read_data <= ram[acc_addr[7:0]];
                    else if (hit_led)
                        bus.read_data <= {8'h00, led_out};
                    else
                        bus.read_data <= {8'h00, sw_in};
                end else if (hit_led)
                    led_out <= acc_wdata[7:0];
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (0, 1 and 3 wait states), directed
// vector table, multi-cycle corner sequences and randomized traffic against a model.
module tb_mem_responder;
    localparam logic [1:0] MNONE = 2'b00, MREAD = 2'b01, MWRITE = 2'b11, MILL = 2'b10;
    localparam logic [8:0] LED_A = 9'h100, SW_A = 9'h140;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_n;
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  sw;

    logic [7:0]  led_a [3];
    logic [15:0] rd_a  [3];
    logic        rdy_a [3];
    logic        err_a [3];

    for (genvar g = 0; g < 3; g++) begin : u
        mem_responder_if bus ();
        logic [7:0] led;
        assign bus.mem_cmd    = cmd;
        assign bus.mem_addr   = addr;
        assign bus.write_data = wdata;
        assign rd_a[g]  = bus.read_data;
        assign rdy_a[g] = bus.mem_ready;
        assign err_a[g] = bus.bus_err;
        assign led_a[g] = led;
        mem_responder #(
            .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 1 : 3),
            .LED_ADDR(LED_A),
            .SW_ADDR(SW_A)
        ) dut (
            .clk(clk),
            .reset_n(rst_n[g]),
            .bus(bus),
            .led_out(led),
            .sw_in(sw)
        );
    end

    int nvec = 0;
    int nmis = 0;
    int sel  = 1;

    // Reference model state for the instance under test
    logic [15:0] mdl_ram   [256];
    logic        mdl_known [256];
    logic [7:0]  mdl_led;
    logic [15:0] mdl_rd;
    logic        mdl_rd_known;

    typedef struct {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic [7:0]  sw;
        logic [15:0] rd;
        logic        err;
        logic [7:0]  led;
    } vec_t;
    vec_t tbl [13];

    function automatic int wait_of(input int s);
        return (s == 0) ? 0 : (s == 1) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s (inst %0d, t=%0t): got %h expected %h", nm, sel, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mdl_led      = 8'h00;
        mdl_rd       = 16'h0000;
        mdl_rd_known = 1'b1;
    endtask

    task automatic model_new_inst();
        for (int i = 0; i < 256; i++) mdl_known[i] = 1'b0;
        model_reset();
    endtask

    task automatic model_step(input logic [1:0] c, input logic [8:0] a, input logic [15:0] wd,
                              input logic [7:0] s, output logic [15:0] erd, output logic eerr,
                              output logic eknown);
        eerr = 1'b0;
        if (c == MILL) begin
            eerr = 1'b1; mdl_rd = 16'h0000; mdl_rd_known = 1'b1;
        end else if (a < 9'd256) begin
            if (c == MREAD) begin
                mdl_rd = mdl_ram[a[7:0]]; mdl_rd_known = mdl_known[a[7:0]];
            end else begin
                mdl_ram[a[7:0]] = wd; mdl_known[a[7:0]] = 1'b1;
            end
        end else if (a == LED_A) begin
            if (c == MREAD) begin mdl_rd = {8'h00, mdl_led}; mdl_rd_known = 1'b1; end
            else mdl_led = wd[7:0];
        end else if (a == SW_A) begin
            if (c == MREAD) begin mdl_rd = {8'h00, s}; mdl_rd_known = 1'b1; end
        end else begin
            eerr = 1'b1; mdl_rd = 16'h0000; mdl_rd_known = 1'b1;
        end
        erd    = mdl_rd;
        eknown = mdl_rd_known;
    endtask

    // Starts and ends on a falling edge; the command is dropped once mem_ready is seen.
    task automatic run_txn(input logic [1:0] c, input logic [8:0] a, input logic [15:0] wd,
                           input logic [7:0] s, output logic [15:0] rd, output logic er,
                           output logic [7:0] ld);
        logic [15:0] erd;
        logic eerr, eknown;
        int lat;
        model_step(c, a, wd, s, erd, eerr, eknown);
        cmd = c; addr = a; wdata = wd; sw = s;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); @(negedge clk);
            if (rdy_a[sel]) begin lat = i; break; end
        end
        rd = rd_a[sel]; er = err_a[sel]; ld = led_a[sel];
        cmd = MNONE;
        chk("latency", 32'(lat), 32'(wait_of(sel) + 1));
        chk("bus_err", {31'd0, er}, {31'd0, eerr});
        if (eknown) chk("read_data", {16'd0, rd}, {16'd0, erd});
        chk("led_out", {24'd0, ld}, {24'd0, mdl_led});
        @(posedge clk); @(negedge clk);
        chk("ready_width", {31'd0, rdy_a[sel]}, 32'd0);
    endtask

    task automatic random_phase(input int n);
        logic [1:0] c; logic [8:0] a; logic [15:0] rd; logic er; logic [7:0] ld;
        int r;
        for (int k = 0; k < n; k++) begin
            r = int'($urandom_range(0, 9));
            c = (r == 0) ? MILL : (r < 5) ? MREAD : MWRITE;
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = LED_A;
            else if (r == 1) a = SW_A;
            else if (r == 2) begin
                a = 9'($urandom_range(257, 511));
                if (a == LED_A || a == SW_A) a = 9'h1FF;
            end else a = 9'($urandom_range(0, 15));
            run_txn(c, a, 16'($urandom), 8'($urandom), rd, er, ld);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(negedge clk);
        end
    endtask

    task automatic switch_to(input int s);
        @(negedge clk);
        rst_n[sel] = 1'b0;
        sel = s;
        model_new_inst();
        rst_n[sel] = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] rd; logic er; logic [7:0] ld;
        tbl[0]  = '{MWRITE, 9'h005, 16'hBEEF, 8'h00, 16'h0000, 1'b0, 8'h00};
        tbl[1]  = '{MREAD,  9'h005, 16'h0000, 8'h00, 16'hBEEF, 1'b0, 8'h00};
        tbl[2]  = '{MWRITE, 9'h100, 16'h12A5, 8'h00, 16'hBEEF, 1'b0, 8'hA5};
        tbl[3]  = '{MREAD,  9'h100, 16'h0000, 8'h00, 16'h00A5, 1'b0, 8'hA5};
        tbl[4]  = '{MREAD,  9'h140, 16'h0000, 8'h3C, 16'h003C, 1'b0, 8'hA5};
        tbl[5]  = '{MWRITE, 9'h140, 16'hFFFF, 8'h3C, 16'h003C, 1'b0, 8'hA5};
        tbl[6]  = '{MREAD,  9'h1FF, 16'h0000, 8'h3C, 16'h0000, 1'b1, 8'hA5};
        tbl[7]  = '{MWRITE, 9'h000, 16'h1234, 8'h3C, 16'h0000, 1'b0, 8'hA5};
        tbl[8]  = '{MILL,   9'h000, 16'h9999, 8'h3C, 16'h0000, 1'b1, 8'hA5};
        tbl[9]  = '{MREAD,  9'h000, 16'h0000, 8'h3C, 16'h1234, 1'b0, 8'hA5};
        tbl[10] = '{MWRITE, 9'h0FF, 16'h0A0A, 8'h3C, 16'h1234, 1'b0, 8'hA5};
        tbl[11] = '{MREAD,  9'h0FF, 16'h0000, 8'h3C, 16'h0A0A, 1'b0, 8'hA5};
        tbl[12] = '{MWRITE, 9'h1FF, 16'h7777, 8'h3C, 16'h0000, 1'b1, 8'hA5};

        rst_n = 3'b000; cmd = MNONE; addr = '0; wdata = '0; sw = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            sel = g;
            chk("reset_led", {24'd0, led_a[g]}, 32'd0);
            chk("reset_ready", {31'd0, rdy_a[g]}, 32'd0);
            chk("reset_rd", {16'd0, rd_a[g]}, 32'd0);
            chk("reset_err", {31'd0, err_a[g]}, 32'd0);
        end

        // One wait state: directed vectors
        sel = 1;
        model_new_inst();
        rst_n[1] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            run_txn(tbl[i].cmd, tbl[i].addr, tbl[i].wdata, tbl[i].sw, rd, er, ld);
            chk("vec_rd", {16'd0, rd}, {16'd0, tbl[i].rd});
            chk("vec_err", {31'd0, er}, {31'd0, tbl[i].err});
            chk("vec_led", {24'd0, ld}, {24'd0, tbl[i].led});
        end

        // Held read: pulses every 3 cycles, address change while busy is ignored
        cmd = MREAD; addr = 9'h005;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); @(negedge clk);
            chk("held_ready", {31'd0, rdy_a[1]}, (i % 3 == 2) ? 32'd1 : 32'd0);
            if (i % 3 == 2)
                chk("held_rd", {16'd0, rd_a[1]}, (i == 2) ? 32'h0000BEEF : 32'h00000A0A);
            if (i == 1) addr = 9'h0FF;
        end
        cmd = MNONE;
        mdl_rd = 16'h0A0A; mdl_rd_known = 1'b1;
        @(negedge clk);
        random_phase(40);

        // Zero wait states
        switch_to(0);
        run_txn(MREAD, 9'h000, 16'h0000, 8'h00, rd, er, ld);
        random_phase(40);

        // Three wait states, then reset during the second busy cycle of a write
        switch_to(2);
        run_txn(MREAD, 9'h000, 16'h0000, 8'h00, rd, er, ld);
        run_txn(MWRITE, 9'h010, 16'h1111, 8'h00, rd, er, ld);
        run_txn(MWRITE, LED_A, 16'h00C3, 8'h00, rd, er, ld);
        cmd = MWRITE; addr = 9'h010; wdata = 16'h5555;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n[2] = 1'b0;
        #1;
        chk("abort_ready", {31'd0, rdy_a[2]}, 32'd0);
        chk("abort_led", {24'd0, led_a[2]}, 32'd0);
        cmd = MNONE;
        @(negedge clk);
        rst_n[2] = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_quiet", {31'd0, rdy_a[2]}, 32'd0);
        end
        run_txn(MREAD, 9'h010, 16'h0000, 8'h00, rd, er, ld);
        chk("abort_ram", {16'd0, rd}, 32'h00001111);
        random_phase(40);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
